zrb_fifo_rd_stream: RTL and testbench

// Read-side adapter placed directly downstream of zrb_fifo, in the rd_clk domain.

---
 rtl/zrb_fifo_rd_stream.sv | 73 +++++++
 tb/tb_zrb_fifo_rd_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zrb_fifo_rd_stream.sv
// Show-ahead valid/ready adapter for the zrb_fifo registered read port.
// A two-entry head/skid buffer keeps one word per clock flowing under back-pressure.
module zrb_fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_count
);

  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic                  infl;
  logic                  pop;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;

  // Counting the word leaving this cycle lets a full buffer still issue a read.
  always_comb begin
    pop        = m_valid & m_ready;
    pending    = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    fifo_rd_en = reset_n & ~flush & ~fifo_empty & (pending < 3'd2);
  end

  always_comb begin
    occ_nxt = occ;
    case ({infl, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      occ        <= '0;
      infl       <= 1'b0;
      m_valid    <= 1'b0;
      head       <= '0;
      skid       <= '0;
      word_count <= '0;
    end else begin
      infl <= fifo_rd_en;
      if (pop) word_count <= word_count + CNT_WIDTH'(1);
      if (flush) begin
        occ     <= '0;
        m_valid <= 1'b0;
      end else begin
        occ     <= occ_nxt;
        m_valid <= (occ_nxt != 2'd0);
        if (pop && occ == 2'd2) begin
          head <= skid;
          if (infl) skid <= fifo_data;
        end else if (infl) begin
          if (occ == 2'd0 || pop) head <= fifo_data;
          else                    skid <= fifo_data;
        end
      end
    end
  end

  assign m_data = head;

endmodule

// File: tb/tb_zrb_fifo_rd_stream.sv
// Bench for zrb_fifo_rd_stream: a queue-based FIFO feeds the DUT and a scoreboard
// tracks every word taken from the FIFO until it leaves on the stream.
module tb_zrb_fifo_rd_stream;
  localparam int unsigned DW = 8;

  logic          rd_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          empty_force = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en, rd_en4;
  logic          m_valid, m_valid4;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data, m_data4;
  logic [15:0]   word_count;
  logic [3:0]    word_count4;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            fifo_lvl = 0;
  int            model_count = 0;
  int            checks = 0;
  int            failures = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  zrb_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
    .rd_clk(rd_clk), .reset_n(reset_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .word_count(word_count)
  );

  zrb_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
    .rd_clk(rd_clk), .reset_n(reset_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en4), .fifo_data(fifo_data), .m_valid(m_valid4),
    .m_ready(m_ready), .m_data(m_data4), .word_count(word_count4)
  );

  assign fifo_empty = (fifo_lvl == 0) || empty_force;

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Registered read port: data_out shows the popped word one clock after rd_en.
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fifo_q.pop_front();
      fifo_lvl  <= fifo_q.size();
    end
  end

  // Scoreboard: every issued read becomes an expected word, in order, until a flush.
  always @(negedge rd_clk) begin
    if (!reset_n) begin
      exp_q.delete();
      model_count = 0;
      hold_prev   = 1'b0;
    end else begin
      if (fifo_empty) begin
        chk("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
        chk("rd_en4_while_empty", 32'(rd_en4), 32'd0);
      end
      chk("word_count", 32'(word_count), 32'(model_count % 65536));
      chk("word_count4", 32'(word_count4), 32'(model_count % 16));
      if (hold_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(data_prev));
      end
      if (exp_q.size() == 0) begin
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_valid4", 32'(m_valid4), 32'd0);
      end else if (m_valid && m_ready) begin
        chk("stream_data4", 32'(m_data4), 32'(exp_q[0]));
        chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        model_count++;
      end
      hold_prev = m_valid && !m_ready && !flush;
      data_prev = m_data;
      if (flush) exp_q.delete();
      if (fifo_rd_en && fifo_q.size() > 0) exp_q.push_back(fifo_q[0]);
      chk("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_lvl = fifo_q.size();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    m_ready = 1'b1;
    empty_force = 1'b0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid) && n < 300) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  initial begin
    logic          ev[6];
    logic [DW-1:0] ed[6];
    logic [DW-1:0] got[$];
    logic [DW-1:0] order[4];
    logic [15:0]   wc;
    int            pulses;
    int            base;
    int            n;

    cyc(2);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // 1: three preloaded words stream back to back from clk 2
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    load(8'h11); load(8'h22); load(8'h33);
    m_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge rd_clk);
      if (c == 0) chk("t1_rd_en_c0", 32'(fifo_rd_en), 32'd1);
      if (fifo_rd_en) pulses++;
      chk("t1_valid", 32'(m_valid), 32'(ev[c]));
      if (ev[c]) chk("t1_data", 32'(m_data), 32'(ed[c]));
      @(posedge rd_clk); #1;
    end
    chk("t1_rd_pulses", 32'(pulses), 32'd3);
    chk("t1_count", 32'(word_count), 32'd3);

    // 2: back-pressure caps outstanding reads at two
    m_ready = 1'b0;
    order = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) load(order[i]);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) pulses++;
      if (c >= 2) begin
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_head", 32'(m_data), 32'h11);
      end
      @(posedge rd_clk); #1;
    end
    chk("t2_rd_pulses", 32'(pulses), 32'd2);
    m_ready = 1'b1;
    n = 0;
    while (got.size() < 4 && n < 20) begin
      @(negedge rd_clk);
      if (m_valid && m_ready) got.push_back(m_data);
      @(posedge rd_clk); #1;
      n++;
    end
    chk("t2_collected", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("t2_order", 32'(got[i]), 32'(order[i]));
    drain("t2_drain");

    // 3: toggling empty with random back-pressure, 1000 words
    base = model_count;
    for (int i = 0; i < 1000; i++) load(DW'($urandom));
    n = 0;
    while (model_count - base < 1000 && n < 20000) begin
      empty_force = ~empty_force;
      m_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    chk("t3_delivered", 32'(model_count - base), 32'd1000);
    chk("t3_word_count", 32'(word_count), 32'((base + 1000) % 65536));
    drain("t3_drain");

    // 4a: flush with one buffered and one in-flight word
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i));
    cyc(2);
    flush = 1'b1;
    wc = word_count;
    cyc(1);
    flush = 1'b0;
    chk("t4a_valid_after_flush", 32'(m_valid), 32'd0);
    chk("t4a_count_kept", 32'(word_count), 32'(wc));
    m_ready = 1'b1;
    wait_valid("t4a_next_valid");
    chk("t4a_next_word", 32'(m_data), 32'hA2);
    drain("t4a_drain");

    // 4b: flush a full buffer while a pop happens in the same cycle
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(8'hB0 + 8'(i));
    cyc(3);
    flush = 1'b1;
    m_ready = 1'b1;
    wc = word_count;
    @(negedge rd_clk);
    chk("t4b_rd_en_flush", 32'(fifo_rd_en), 32'd0);
    @(posedge rd_clk); #1;
    flush = 1'b0;
    chk("t4b_valid_after_flush", 32'(m_valid), 32'd0);
    chk("t4b_count_pop", 32'(word_count), 32'(wc + 16'd1));
    wait_valid("t4b_next_valid");
    chk("t4b_next_word", 32'(m_data), 32'hB2);
    drain("t4b_drain");

    // 5: asynchronous reset with a full buffer and data still in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
    cyc(3);
    reset_n = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_data", 32'(m_data), 32'd0);
    chk("t5_count", 32'(word_count), 32'd0);
    chk("t5_count4", 32'(word_count4), 32'd0);
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge rd_clk);
    chk("t5_rd_en_neg", 32'(fifo_rd_en), 32'd0);
    @(posedge rd_clk); #1;
    chk("t5_valid_held", 32'(m_valid), 32'd0);
    fifo_q.delete();
    fifo_lvl = 0;
    reset_n = 1'b1;
    m_ready = 1'b1;
    cyc(2);
    chk("t5_no_partial", 32'(m_valid), 32'd0);

    // 6: 4-bit counter wraps after 16 transfers
    for (int i = 0; i < 17; i++) load(8'h60 + 8'(i));
    n = 0;
    while (model_count < 17 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t6_transfers", 32'(model_count), 32'd17);
    chk("t6_wc4_wrapped", 32'(word_count4), 32'd1);
    chk("t6_wc16", 32'(word_count), 32'd17);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
